// File: rtl/core_pkg.sv
// Shared core definitions: result-source codes and register-file geometry.
// Used by the writeback result queue and its storage array.
package core_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        RS_ALU = 2'b00,
        RS_MEM = 2'b01,
        RS_PC4 = 2'b10,
        RS_RSV = 2'b11
    } rs_e;

    // Only the memory and PC+4 sources produce a register writeback.
    function automatic logic is_wb_src(input logic [1:0] src);
        return src[1] ^ src[0];
    endfunction

endpackage

// File: rtl/wb_result_queue_mem.sv
// Storage array for the writeback queue: one synchronous write port,
// one asynchronous read port, cleared on reset so reads are never X.
module wb_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int DW    = 37,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_result_queue.sv
// Writeback result queue: filters results by source, buffers them and
// drains one entry per register-file write, holding the last retired value.
module wb_result_queue
    import core_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = REG_AW,
    parameter int DEPTH = 4,
    localparam int IW   = $clog2(DEPTH),
    localparam int PW   = IW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [AW-1:0]    in_rd,
    input  logic [1:0]       in_src,
    output logic             rf_we,
    output logic [AW-1:0]    rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    input  logic             rf_ready,
    output logic [WIDTH-1:0] held_result,
    output logic [PW-1:0]    count,
    output logic [7:0]       drop_cnt
);

    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                push;
    logic                store;
    logic                pop;
    logic [AW+WIDTH-1:0] head;

    // Pointers carry one extra wrap bit, so their difference is occupancy.
    assign count    = wr_ptr - rd_ptr;
    assign in_ready = (count != FULL);
    assign rf_we    = (count != '0);

    assign push  = in_valid && in_ready;
    assign store = push && is_wb_src(in_src) && (in_rd != '0);
    assign pop   = rf_we && rf_ready;

    assign {rf_wa, rf_wd} = head;

    wb_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (AW + WIDTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (store),
        .waddr (wr_ptr[IW-1:0]),
        .wdata ({in_rd, in_result}),
        .raddr (rd_ptr[IW-1:0]),
        .rdata (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            held_result <= '0;
            drop_cnt    <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                held_result <= rf_wd;
            end
            if (push && !store && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_result_queue.sv
// Scoreboard bench for wb_result_queue: the driver queues expected writes
// on each accepted result, the monitor checks every register-file write.
module tb_wb_result_queue;

    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_result;
    logic [AW-1:0] in_rd;
    logic [1:0]    in_src;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [W-1:0]  rf_wd;
    logic          rf_ready;
    logic [W-1:0]  held_result;
    logic [CW-1:0] count;
    logic [7:0]    drop_cnt;

    wb_result_queue #(
        .WIDTH (W),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_rd       (in_rd),
        .in_src      (in_src),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .rf_ready    (rf_ready),
        .held_result (held_result),
        .count       (count),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queued writes, last retired value, drop tally.
    logic [AW+W-1:0] exp_q[$];
    logic [W-1:0]    exp_held;
    int              exp_drop;
    bit              mon_en;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [1:0] src, input logic [AW-1:0] rd,
                                input logic [W-1:0] d);
        if ((src == 2'b01 || src == 2'b10) && rd != 0) begin
            exp_q.push_back({rd, d});
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        exp_held = '0;
        exp_drop = 0;
    endtask

    task automatic send(input logic [1:0] src, input logic [AW-1:0] rd,
                        input logic [W-1:0] d, input bit rnd_rdy);
        bit hs;
        hs        = 1'b0;
        in_valid  = 1'b1;
        in_src    = src;
        in_rd     = rd;
        in_result = d;
        for (int k = 0; k < 50 && !hs; k++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) model_accept(src, rd, d);
            else if (rnd_rdy) rf_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got no accept expected accept");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle compare state against the model, retire on write.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
            chk("rf_we", 32'(rf_we), 32'(exp_q.size() != 0));
            chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
            chk("held_result", held_result, exp_held);
            if (exp_q.size() != 0) begin
                chk("rf_wa", 32'(rf_wa), 32'(exp_q[0][AW+W-1:W]));
                chk("rf_wd", rf_wd, exp_q[0][W-1:0]);
                if (rf_ready) begin
                    exp_held = exp_q[0][W-1:0];
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        mon_en    = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_rd     = '0;
        in_src    = '0;
        rf_ready  = 1'b0;
        do_reset();
        idle(2);
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_held", held_result, 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Single write with immediate retire
        rf_ready = 1'b1;
        send(2'b01, 5'd5, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("one_rf_we", 32'(rf_we), 32'd1);
        chk("one_rf_wa", 32'(rf_wa), 32'd5);
        chk("one_rf_wd", rf_wd, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        chk("one_held", held_result, 32'hDEADBEEF);
        chk("one_count", 32'(count), 32'd0);

        // Fill, back-pressure, then drain in order
        rf_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(2'b01, 5'(i), 32'(i), 1'b0);
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        fork
            send(2'b10, 5'd6, 32'd5, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("held_off_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                rf_ready = 1'b1;
            end
        join
        idle(8);
        chk("after_fill_held", held_result, 32'd5);

        // Drops: bad source codes and x0 destination
        send(2'b00, 5'd3, 32'h11, 1'b0);
        send(2'b11, 5'd4, 32'h22, 1'b0);
        send(2'b10, 5'd0, 32'h33, 1'b0);
        @(negedge clk);
        chk("drop_count", 32'(count), 32'd0);
        chk("drop_cnt3", 32'(drop_cnt), 32'd3);
        chk("drop_held", held_result, 32'd5);
        @(posedge clk);
        #1;

        // Steady push+pop at occupancy 2, wrapping pointers
        rf_ready = 1'b0;
        send(2'b01, 5'd7, 32'd100, 1'b0);
        send(2'b10, 5'd8, 32'd101, 1'b0);
        rf_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(2'b01, 5'(i + 1), 32'(200 + i), 1'b0);
        @(negedge clk);
        chk("stream_count", 32'(count), 32'd2);
        @(posedge clk);
        #1;
        idle(4);

        // Asynchronous reset with entries in flight
        rf_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(2'b01, 5'(10 + i), 32'(300 + i), 1'b0);
        #2;
        do_reset();
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_we", 32'(rf_we), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_held", held_result, 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(2'b10, 5'd9, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_wa", 32'(rf_wa), 32'd9);
        chk("post_rst_wd", rf_wd, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        rf_ready = 1'b1;
        idle(2);
        chk("post_rst_held", held_result, 32'hCAFEF00D);

        // Random traffic with random register-file back-pressure
        for (int i = 0; i < 400; i++) begin
            rf_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) idle(1);
            send(2'($urandom), 5'($urandom), $urandom, 1'b1);
        end
        rf_ready = 1'b1;
        idle(6);

        // Drop counter saturation
        for (int i = 0; i < 270; i++) send(2'b00, 5'd1, 32'(i), 1'b0);
        @(negedge clk);
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        @(posedge clk);
        #1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
